// File: rtl/l2_resp_pkg.sv
// Shared definitions for the L2 fill responder and its line-merge helper.
//   state_e        : responder FSM states
//   SZ_*           : write size encodings (log2 of byte count)
//   LINE_BYTES_DFLT: default bytes per line
package l2_resp_pkg;

  localparam int LINE_BYTES_DFLT = 16;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/l2_line_merge.sv
// Combinational byte-lane merge of a 1/2/4/8-byte store into a cache line.
// Ports:
//   line   in  : current line image
//   wdata  in  : store data, LSB-aligned
//   offset in  : byte offset of the store within the line
//   size   in  : log2 of the store size; 4..7 are illegal
//   merged out : line with the store bytes replaced (equals line when err)
//   err    out : illegal size or store would cross the end of the line
module l2_line_merge
  import l2_resp_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DFLT
) (
  input  logic [8*LINE_BYTES-1:0]         line,
  input  logic [63:0]                     wdata,
  input  logic [$clog2(LINE_BYTES)-1:0]   offset,
  input  logic [2:0]                      size,
  output logic [8*LINE_BYTES-1:0]         merged,
  output logic                            err
);

  int nbytes;
  int off;

  always_comb begin
    merged = line;
    nbytes = 1 << size[1:0];
    off    = int'(offset);
    err    = (size > SZ_D) || (off + nbytes > LINE_BYTES);
    if (!err) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (i >= off && i < off + nbytes) begin
          merged[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/l2_fill_responder.sv
// Fixed-latency line responder below L1_D. Accepts one miss/forward request
// at a time, services it against a line-organised backing store and returns
// the affected line with a one-cycle done pulse.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   req_valid_in      : request present
//   req_ready_out     : high only in IDLE
//   write_enable_in   : 1 = write, 0 = read
//   write_data_in     : store data, LSB-aligned
//   address_in        : byte address (high bits alias)
//   write_size_in     : log2 bytes, 0..3 legal
//   CLF_in            : line flush; overrides write_enable_in
//   data_out          : response line, held between responses
//   done_out          : one-cycle completion pulse
//   error_out         : rejected request, only meaningful with done_out
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown, request captured
// RESP  | done pulse, write commits at the closing edge
module l2_fill_responder
  import l2_resp_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DFLT,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic                    write_enable_in,
  input  logic [63:0]             write_data_in,
  input  logic [63:0]             address_in,
  input  logic [2:0]              write_size_in,
  input  logic                    CLF_in,
  output logic [8*LINE_BYTES-1:0] data_out,
  output logic                    done_out,
  output logic                    error_out
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LINE_W = 8 * LINE_BYTES;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] idx_q;
  logic [OFF_W-1:0] off_q;
  logic [63:0]      wdata_q;
  logic [2:0]       size_q;
  logic             we_q;
  logic             clf_q;

  logic [LINE_W-1:0] mem [MEM_LINES];
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] merged;
  logic [LINE_W-1:0] resp_line;
  logic [LINE_W-1:0] data_q;
  logic              merge_err;
  logic              error_q;
  logic              accept;
  logic              resp_load;
  logic              commit;

  // Address bits above the line index alias silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address_in[63:OFF_W+IDX_W];

  assign req_ready_out = (state_q == IDLE);
  assign accept        = req_valid_in && req_ready_out;
  assign resp_load     = (state_q == WAIT) && (cnt_q == 4'd0);
  assign commit        = (state_q == RESP) && we_q && !clf_q && !error_q;

  assign cur_line = mem[idx_q];

  l2_line_merge #(
    .LINE_BYTES (LINE_BYTES)
  ) u_merge (
    .line   (cur_line),
    .wdata  (wdata_q),
    .offset (off_q),
    .size   (size_q),
    .merged (merged),
    .err    (merge_err)
  );

  always_comb begin
    resp_line = cur_line;
    if (merge_err) begin
      resp_line = '0;
    end else if (we_q && !clf_q) begin
      resp_line = merged;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      clf_q   <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= address_in[OFF_W +: IDX_W];
        off_q   <= address_in[OFF_W-1:0];
        wdata_q <= write_data_in;
        size_q  <= write_size_in;
        we_q    <= write_enable_in;
        clf_q   <= CLF_in;
      end
      // The response line is latched on entry to RESP so data_out stays
      // stable afterwards and matches exactly what the commit writes.
      if (resp_load) begin
        data_q  <= resp_line;
        error_q <= merge_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= data_q;
    end
  end

  assign data_out  = data_q;
  assign done_out  = (state_q == RESP);
  assign error_out = error_q && (state_q == RESP);

endmodule

// File: tb/tb_l2_fill_responder.sv
module tb_l2_fill_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_in = 1'b0;
  logic         req_ready_out;
  logic         write_enable_in = 1'b0;
  logic [63:0]  write_data_in = '0;
  logic [63:0]  address_in = '0;
  logic [2:0]   write_size_in = '0;
  logic         CLF_in = 1'b0;
  logic [127:0] data_out;
  logic         done_out;
  logic         error_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_fill_responder #(
    .LINE_BYTES (16),
    .MEM_LINES  (1024),
    .LATENCY    (LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_in    (req_valid_in),
    .req_ready_out   (req_ready_out),
    .write_enable_in (write_enable_in),
    .write_data_in   (write_data_in),
    .address_in      (address_in),
    .write_size_in   (write_size_in),
    .CLF_in          (CLF_in),
    .data_out        (data_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  typedef struct {
    logic         we;
    logic         clf;
    logic         hold;
    logic [63:0]  addr;
    logic [63:0]  wdata;
    logic [2:0]   sz;
    logic         chk_line;
    logic [127:0] exp_line;
    logic         exp_err;
  } vec_t;

  vec_t vecs[15];

  // Reference store: 8 lines of 16 bytes, addressed by index bits [6:4].
  logic [7:0] ref_mem [8][16];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic clf, input logic hold,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [2:0] sz, input logic chk,
                              input logic [127:0] line, input logic err);
    vec_t v;
    v.we = we; v.clf = clf; v.hold = hold; v.addr = addr; v.wdata = wdata;
    v.sz = sz; v.chk_line = chk; v.exp_line = line; v.exp_err = err;
    return v;
  endfunction

  function automatic void model(input logic we, input logic clf, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [2:0] sz,
                                output logic [127:0] line, output logic err);
    int l;
    int off;
    int n;
    l   = int'(addr[6:4]);
    off = int'(addr[3:0]);
    n   = 1 << int'(sz);
    err = (sz > 3'd3) || (off + n > 16);
    line = '0;
    if (!err) begin
      if (we && !clf) begin
        for (int b = 0; b < n; b++) ref_mem[l][off+b] = wdata[8*b +: 8];
      end
      for (int i = 0; i < 16; i++) line[8*i +: 8] = ref_mem[l][i];
    end
  endfunction

  // Issues one request from IDLE and waits for its done pulse.
  // lat = number of edges after the accept edge before done is seen (-1 on timeout).
  task automatic do_req(input string name, input logic we, input logic clf, input logic hold,
                        input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] sz,
                        output logic [127:0] line, output logic err, output int lat);
    logic rdy_in_wait;
    rdy_in_wait = 1'b0;
    line = '0;
    err  = 1'b0;
    lat  = -1;
    @(negedge clk);
    check({name, "_ready"}, 128'(req_ready_out), 128'(1));
    req_valid_in    = 1'b1;
    write_enable_in = we;
    CLF_in          = clf;
    address_in      = addr;
    write_data_in   = wdata;
    write_size_in   = sz;
    @(posedge clk);
    #1;
    if (!hold) req_valid_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_out) begin
        lat  = k;
        line = data_out;
        err  = error_out;
        break;
      end
      if (req_ready_out) rdy_in_wait = 1'b1;
    end
    check({name, "_lat"}, 128'(lat), 128'(LAT));
    check({name, "_busy"}, 128'(rdy_in_wait), 128'(0));
    @(negedge clk);
    req_valid_in = 1'b0;
    check({name, "_pulse"}, 128'(done_out), 128'(0));
    check({name, "_errq"}, 128'(error_out), 128'(0));
    check({name, "_hold"}, data_out, line);
  endtask

  localparam logic [127:0] P  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W1 = 128'h00112233_44556677_DEADBEEF_CCDDEEFF;
  localparam logic [127:0] W2 = 128'hA5112233_44556677_DEADBEEF_CCDDEEFF;
  localparam logic [127:0] W3 = 128'h12342233_44556677_DEADBEEF_CCDDEEFF;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line;
    logic         err;
    int           lat;
    logic [127:0] exp_line;
    logic         exp_err;
    int           done_cnt;
    int           n_acc;
    logic         last;
    int           pulse_cyc[$];

    vecs[0]  = mk(1, 0, 0, 64'h30,   64'h8899AABB_CCDDEEFF, 3'd3, 0, '0, 0);
    vecs[1]  = mk(1, 0, 0, 64'h38,   64'h00112233_44556677, 3'd3, 1, P,  0);
    vecs[2]  = mk(0, 0, 0, 64'h30,   64'h0,                 3'd0, 1, P,  0);
    vecs[3]  = mk(1, 0, 0, 64'h34,   64'hDEADBEEF,          3'd2, 1, W1, 0);
    vecs[4]  = mk(0, 0, 0, 64'h30,   64'h0,                 3'd3, 1, W1, 0);
    vecs[5]  = mk(1, 0, 0, 64'h3C,   64'h11111111_11111111, 3'd3, 1, '0, 1);
    vecs[6]  = mk(1, 0, 0, 64'h30,   64'h22222222_22222222, 3'd5, 1, '0, 1);
    vecs[7]  = mk(0, 0, 0, 64'h30,   64'h0,                 3'd0, 1, W1, 0);
    vecs[8]  = mk(1, 1, 1, 64'h30,   64'hFFFFFFFF_FFFFFFFF, 3'd3, 1, W1, 0);
    vecs[9]  = mk(0, 0, 0, 64'h30,   64'h0,                 3'd0, 1, W1, 0);
    vecs[10] = mk(0, 0, 0, 64'h4030, 64'h0,                 3'd0, 1, W1, 0);
    vecs[11] = mk(1, 0, 0, 64'h3F,   64'hA5,                3'd0, 1, W2, 0);
    vecs[12] = mk(1, 0, 0, 64'h3F,   64'h7777,              3'd1, 1, '0, 1);
    vecs[13] = mk(1, 0, 0, 64'h3E,   64'h1234,              3'd1, 1, W3, 0);
    vecs[14] = mk(0, 0, 0, 64'h30,   64'h0,                 3'd0, 1, W3, 0);

    // Reset values
    #1;
    check("rst_ready", 128'(req_ready_out), 128'(1));
    check("rst_done",  128'(done_out), 128'(0));
    check("rst_err",   128'(error_out), 128'(0));
    check("rst_data",  data_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      do_req($sformatf("row%0d", i), vecs[i].we, vecs[i].clf, vecs[i].hold, vecs[i].addr,
             vecs[i].wdata, vecs[i].sz, line, err, lat);
      check($sformatf("row%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
      if (vecs[i].chk_line) check($sformatf("row%0d_line", i), line, vecs[i].exp_line);
    end

    // Reset two cycles after accepting a write
    @(negedge clk);
    req_valid_in = 1'b1; write_enable_in = 1'b1; CLF_in = 1'b0;
    address_in = 64'h30; write_data_in = 64'hFFFFFFFF_FFFFFFFF; write_size_in = 3'd3;
    @(posedge clk);
    #1 req_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", 128'(req_ready_out), 128'(1));
    check("midrst_done",  128'(done_out), 128'(0));
    check("midrst_data",  data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_out) done_cnt++;
    end
    check("midrst_nopulse", 128'(done_cnt), 128'(0));
    do_req("postrst", 0, 0, 0, 64'h30, 64'h0, 3'd0, line, err, lat);
    check("postrst_line", line, W3);

    // Eight back-to-back aliased reads with valid held high
    @(negedge clk);
    req_valid_in = 1'b1; write_enable_in = 1'b0; CLF_in = 1'b0;
    address_in = 64'h4030; write_size_in = 3'd0;
    n_acc = 0;
    last  = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (req_valid_in && req_ready_out) begin
        n_acc++;
        if (n_acc == 8) last = 1'b1;
      end
      @(posedge clk);
      #1;
      if (last) req_valid_in = 1'b0;
      @(negedge clk);
      if (done_out) begin
        pulse_cyc.push_back(cyc);
        check($sformatf("b2b%0d_line", pulse_cyc.size()), data_out, W3);
      end
    end
    check("b2b_accepts", 128'(n_acc), 128'(8));
    check("b2b_pulses", 128'(pulse_cyc.size()), 128'(8));
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      check($sformatf("b2b_gap%0d", i), 128'(pulse_cyc[i] - pulse_cyc[i-1]), 128'(LAT + 2));
    end

    // Randomised: initialise lines 0..7 with full-line writes, then mixed traffic
    for (int l = 0; l < 8; l++) begin
      for (int h = 0; h < 2; h++) begin
        logic [63:0] wd;
        logic [63:0] a;
        wd = {$urandom, $urandom};
        a  = 64'(l * 16 + h * 8);
        model(1'b1, 1'b0, a, wd, 3'd3, exp_line, exp_err);
        do_req($sformatf("init%0d_%0d", l, h), 1'b1, 1'b0, 1'b0, a, wd, 3'd3, line, err, lat);
        check($sformatf("init%0d_%0d_err", l, h), 128'(err), 128'(0));
        if (h == 1) check($sformatf("init%0d_line", l), line, exp_line);
      end
    end
    for (int t = 0; t < 40; t++) begin
      logic        we;
      logic        clf;
      logic [2:0]  sz;
      logic [63:0] a;
      logic [63:0] wd;
      we  = 1'($urandom_range(0, 1));
      clf = ($urandom_range(0, 3) == 0);
      sz  = 3'($urandom_range(0, 5));
      wd  = {$urandom, $urandom};
      a   = {$urandom, $urandom};
      a[13:0] = {7'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      model(we, clf, a, wd, sz, exp_line, exp_err);
      do_req($sformatf("rnd%0d", t), we, clf, 1'b0, a, wd, sz, line, err, lat);
      check($sformatf("rnd%0d_err", t), 128'(err), 128'(exp_err));
      check($sformatf("rnd%0d_line", t), line, exp_line);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
